// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - state encoding, opcode/Funct and ALUControl constants (ILLEGAL_OP_TRAP_EN adds TRAP)
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
`ifdef ILLEGAL_OP_TRAP_EN
    S_JUMP,
    S_TRAP
`else
    S_JUMP
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp/Funct to the 3-bit ALUControl word
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl,
  output logic       funct_valid
);

  logic [2:0] funct_ctrl;

  // funct_valid reflects the Funct field alone; the FSM only consults it in EXECUTE
  always_comb begin
    funct_ctrl  = ALU_ADD;
    funct_valid = 1'b1;
    case (Funct)
      FUNCT_ADD:  funct_ctrl = ALU_ADD;
      FUNCT_SUB:  funct_ctrl = ALU_SUB;
      FUNCT_AND:  funct_ctrl = ALU_AND;
      FUNCT_OR:   funct_ctrl = ALU_OR;
      FUNCT_XOR:  funct_ctrl = ALU_XOR;
      FUNCT_NOR:  funct_ctrl = ALU_NOR;
      FUNCT_SLT:  funct_ctrl = ALU_SLT;
      FUNCT_SLTU: funct_ctrl = ALU_SLTU;
      default:    funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB:   ALUControl = ALU_SUB;
      ALUOP_FUNCT: ALUControl = funct_ctrl;
      default:     ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore multi-cycle control FSM; ILLEGAL_OP_TRAP_EN enables the TRAP state
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Illegal
);

`ifdef ILLEGAL_OP_TRAP_EN
  localparam state_t S_BAD = S_TRAP;
`else
  localparam state_t S_BAD = S_FETCH;
`endif

  state_t     state, next_state;
  logic [1:0] aluop;
  logic       funct_valid;
  logic       ir_write, pc_write, reg_write;

  alu_decoder u_alu_decoder (
    .ALUOp       (aluop),
    .Funct       (Funct),
    .ALUControl  (ALUControl),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    aluop      = ALUOP_ADD;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE:      next_state = S_EXECUTE;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:       next_state = S_ADDIEX;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_BAD;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        MemtoReg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = funct_valid ? S_ALUWB : S_BAD;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        RegDst     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        aluop      = ALUOP_SUB;
        PCSrc      = 2'b01;
        pc_write   = (Op == OP_BEQ) ? Zero : ~Zero;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = state;
    endcase
  end

  // Reset holds the FSM in FETCH with MemReq up; no write may commit until reset is released
  assign IRWrite  = ir_write  & rst_n;
  assign PCWrite  = pc_write  & rst_n;
  assign RegWrite = reg_write & rst_n;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  illegal_q <= 1'b0;
    else if (next_state == S_TRAP) illegal_q <= 1'b1;
  end

  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       MemReq, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCWrite, Illegal;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  function automatic logic [16:0] o(input logic mreq, mw, iord, irw, rw, rd, m2r, sa,
                                    input logic [1:0] sb, input logic [2:0] alu,
                                    input logic [1:0] pcs, input logic pcw, ill);
    return {mreq, mw, iord, irw, rw, rd, m2r, sa, sb, alu, pcs, pcw, ill};
  endfunction

  logic [16:0] obs;
  assign obs = {MemReq, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, PCWrite, Illegal};

  task automatic chk(input string tag, input logic [16:0] exp);
    #1;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [16:0] e_fetch_rdy, e_fetch_wait, e_decode, e_memadr, e_memread, e_memwb;
  logic [16:0] e_memwrite, e_aluwb, e_addiex, e_addiwb, e_jump, e_trap;
  logic [5:0]  funct_tab [8];

  initial begin
    e_fetch_rdy  = o(H,L,L,H,L,L,L,L,2'b01,3'b000,2'b00,H,L);
    e_fetch_wait = o(H,L,L,L,L,L,L,L,2'b01,3'b000,2'b00,L,L);
    e_decode     = o(L,L,L,L,L,L,L,L,2'b11,3'b000,2'b00,L,L);
    e_memadr     = o(L,L,L,L,L,L,L,H,2'b10,3'b000,2'b00,L,L);
    e_memread    = o(H,L,H,L,L,L,L,L,2'b00,3'b000,2'b00,L,L);
    e_memwb      = o(L,L,L,L,H,L,H,L,2'b00,3'b000,2'b00,L,L);
    e_memwrite   = o(H,H,H,L,L,L,L,L,2'b00,3'b000,2'b00,L,L);
    e_aluwb      = o(L,L,L,L,H,H,L,L,2'b00,3'b000,2'b00,L,L);
    e_addiex     = o(L,L,L,L,L,L,L,H,2'b10,3'b000,2'b00,L,L);
    e_addiwb     = o(L,L,L,L,H,L,L,L,2'b00,3'b000,2'b00,L,L);
    e_jump       = o(L,L,L,L,L,L,L,L,2'b00,3'b000,2'b10,H,L);
    e_trap       = o(L,L,L,L,L,L,L,L,2'b00,3'b000,2'b00,L,H);
    funct_tab[0] = 6'h20; funct_tab[1] = 6'h22; funct_tab[2] = 6'h24; funct_tab[3] = 6'h25;
    funct_tab[4] = 6'h26; funct_tab[5] = 6'h27; funct_tab[6] = 6'h2A; funct_tab[7] = 6'h2B;

    // reset with MemReady high: FETCH request, but no write enables
    rst_n = 1'b0; Op = 6'b000000; Funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
    chk("reset_fetch", e_fetch_wait);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add, 4 cycles
    chk("radd_fetch", e_fetch_rdy);    step();
    chk("radd_decode", e_decode);      step();
    chk("radd_exec", o(L,L,L,L,L,L,L,H,2'b00,3'b000,2'b00,L,L)); step();
    chk("radd_aluwb", e_aluwb);        step();

    // memory wait in FETCH holds the request with no enables
    MemReady = 1'b0;
    chk("fetch_wait", e_fetch_wait);   step();
    chk("fetch_wait2", e_fetch_wait);

    // lw with two wait cycles in MEMREAD, 7 cycles total
    Op = 6'b100011; MemReady = 1'b1;
    chk("lw_fetch", e_fetch_rdy);      step();
    chk("lw_decode", e_decode);        step();
    chk("lw_memadr", e_memadr);        step();
    MemReady = 1'b0;
    chk("lw_memread_w1", e_memread);   step();
    chk("lw_memread_w2", e_memread);   step();
    MemReady = 1'b1;
    chk("lw_memread_rdy", e_memread);  step();
    chk("lw_memwb", e_memwb);          step();

    // sw completing normally
    Op = 6'b101011;
    chk("sw_fetch", e_fetch_rdy);      step();
    chk("sw_decode", e_decode);        step();
    chk("sw_memadr", e_memadr);        step();
    chk("sw_memwrite", e_memwrite);    step();

    // beq: PCWrite follows Zero
    Op = 6'b000100; Zero = 1'b1;
    chk("beq_fetch", e_fetch_rdy);     step();
    chk("beq_decode", e_decode);       step();
    chk("beq_taken", o(L,L,L,L,L,L,L,H,2'b00,3'b001,2'b01,H,L));
    Zero = 1'b0;
    chk("beq_not_taken", o(L,L,L,L,L,L,L,H,2'b00,3'b001,2'b01,L,L));
    step();

    // bne: PCWrite follows ~Zero
    Op = 6'b000101; Zero = 1'b1;
    chk("bne_fetch", e_fetch_rdy);     step();
    chk("bne_decode", e_decode);       step();
    chk("bne_zero1", o(L,L,L,L,L,L,L,H,2'b00,3'b001,2'b01,L,L));
    Zero = 1'b0;
    chk("bne_zero0", o(L,L,L,L,L,L,L,H,2'b00,3'b001,2'b01,H,L));
    step();

    // Funct sweep: ALUControl 000..111 in EXECUTE
    Op = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      Funct = funct_tab[i];
      chk($sformatf("sweep%0d_fetch", i), e_fetch_rdy); step();
      step();
      chk($sformatf("sweep%0d_exec", i), o(L,L,L,L,L,L,L,H,2'b00,3'(i),2'b00,L,L)); step();
      chk($sformatf("sweep%0d_aluwb", i), e_aluwb); step();
    end

    // addi
    Op = 6'b001000;
    chk("addi_fetch", e_fetch_rdy);    step();
    chk("addi_decode", e_decode);      step();
    chk("addi_ex", e_addiex);          step();
    chk("addi_wb", e_addiwb);          step();

    // j, 3 cycles
    Op = 6'b000010;
    chk("j_fetch", e_fetch_rdy);       step();
    chk("j_decode", e_decode);         step();
    chk("j_jump", e_jump);             step();
    chk("j_back_fetch", e_fetch_rdy);

    // reset pulse during MEMWRITE aborts immediately
    Op = 6'b101011;                    step();
    step();
    MemReady = 1'b0;                   step();
    chk("swr_memwrite", e_memwrite);
    rst_n = 1'b0;
    chk("swr_reset_fetch", e_fetch_wait);
    MemReady = 1'b1;
    chk("swr_reset_gated", e_fetch_wait);
    rst_n = 1'b1;
    chk("swr_release", e_fetch_rdy);
    step();
    chk("swr_decode", e_decode);       step();
    chk("swr_memadr", e_memadr);       step();
    chk("swr_memwrite2", e_memwrite);  step();

    // unknown Funct in EXECUTE
    Op = 6'b000000; Funct = 6'h21;
    chk("badf_fetch", e_fetch_rdy);    step();
    step();
    chk("badf_exec", o(L,L,L,L,L,L,L,H,2'b00,3'b000,2'b00,L,L)); step();
`ifdef ILLEGAL_OP_TRAP_EN
    chk("badf_trap", e_trap);
    rst_n = 1'b0;
    chk("badf_reset", e_fetch_wait);
    @(negedge clk);
    rst_n = 1'b1;
`else
    chk("badf_nop_fetch", e_fetch_rdy);
`endif

    // unknown opcode 111111
    Op = 6'b111111; Funct = 6'h20;
    chk("badop_fetch", e_fetch_rdy);   step();
    chk("badop_decode", e_decode);     step();
`ifdef ILLEGAL_OP_TRAP_EN
    chk("badop_trap", e_trap);         step();
    step();
    chk("badop_trap_sticky", e_trap);
    rst_n = 1'b0;
    chk("badop_reset_clear", e_fetch_wait);
    @(negedge clk);
    rst_n = 1'b1;
    chk("badop_after_reset", e_fetch_rdy);
`else
    chk("badop_nop_fetch", e_fetch_rdy);
    MemReady = 1'b0;                   step();
    chk("badop_idle", e_fetch_wait);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
